// File: rtl/reg_file_2r_clr_pkg.sv
// Shared constants for the clearable two-read-port register file.
package reg_file_2r_clr_pkg;

  // FSM state encodings for the clear sweep controller.
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  // Returns 1 when the given state is the sweep state.
  function automatic logic is_clear_state(input logic [0:0] st);
    return (st == ST_CLEAR);
  endfunction

endpackage

// File: rtl/reg_file_2r_clr_sweep_fsm.sv
// Clear sweep controller: walks every entry once, writing INIT, after reset or clr.
module clr_sweep_fsm
  import reg_file_2r_clr_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  output logic         busy,
  output logic         sweep_we,
  output logic [W-1:0] sweep_addr
);

  localparam logic [W-1:0] LAST_ADDR = {W{1'b1}};

  logic [0:0]   state_r;
  logic [0:0]   state_nxt_s;
  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;
  logic         busy_s;

  // State and sweep counter registers; reset restarts the sweep from entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: finish after the last entry, clr only honoured when idle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        cnt_nxt_s = cnt_r + W'(1'b1);
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = {W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = {W{1'b0}};
      end
    endcase
  end

  // Output decode taken purely from the state/counter registers.
  always_comb begin
    busy_s = is_clear_state(state_r);
  end

  assign busy       = busy_s;
  assign sweep_we   = busy_s;
  assign sweep_addr = cnt_r;

endmodule

// File: rtl/reg_file_2r_clr.sv
// Register file with one write port, two registered write-first read ports,
// and a self-clearing sweep that loads INIT into every entry.
module reg_file_2r_clr
  import reg_file_2r_clr_pkg::*;
#(
  parameter int             B    = 8,
  parameter int             W    = 2,
  parameter logic [B-1:0]   INIT = {B{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr0,
  input  logic [W-1:0] r_addr1,
  output logic [B-1:0] r_data0,
  output logic [B-1:0] r_data1,
  output logic         busy
);

  localparam int DEPTH = 1 << W;

  logic [B-1:0] mem_r [0:DEPTH-1];
  logic [B-1:0] r_data0_r;
  logic [B-1:0] r_data1_r;

  logic         busy_s;
  logic         sweep_we_s;
  logic [W-1:0] sweep_addr_s;

  logic         user_we_s;
  logic         mem_we_s;
  logic [W-1:0] mem_waddr_s;
  logic [B-1:0] mem_wdata_s;
  logic         hit0_s;
  logic         hit1_s;

  clr_sweep_fsm #(
    .W (W)
  ) u_sweep (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .busy       (busy_s),
    .sweep_we   (sweep_we_s),
    .sweep_addr (sweep_addr_s)
  );

  // Write mux: the sweep owns the array; a user write needs idle and no clr.
  always_comb begin
    user_we_s = 1'b0;
    if (!busy_s && !clr && wr_en) begin
      user_we_s = 1'b1;
    end else begin
      user_we_s = 1'b0;
    end
    if (sweep_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = sweep_addr_s;
      mem_wdata_s = INIT;
    end else begin
      mem_we_s    = user_we_s;
      mem_waddr_s = w_addr;
      mem_wdata_s = w_data;
    end
    hit0_s = user_we_s && (w_addr == r_addr0);
    hit1_s = user_we_s && (w_addr == r_addr1);
  end

  // Storage array; entries are initialised by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Read registers: INIT while sweeping, else write-first bypass or array data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data0_r <= INIT;
      r_data1_r <= INIT;
    end else if (busy_s) begin
      r_data0_r <= INIT;
      r_data1_r <= INIT;
    end else begin
      r_data0_r <= hit0_s ? w_data : mem_r[r_addr0];
      r_data1_r <= hit1_s ? w_data : mem_r[r_addr1];
    end
  end

  assign r_data0 = r_data0_r;
  assign r_data1 = r_data1_r;
  assign busy    = busy_s;

endmodule
